hex_scan_display: RTL and testbench
===================================

# hex_scan_display

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits plus one sign digit. It is the multi-digit successor to the single-digit hex/sign decoder. It captures a packed hex value and sign, applies the update only at frame boundaries so the display never tears, optionally blanks leading zeros, and scans one digit at a time with a dead-time cycle between digits. It sits between the processor's result/output register and the board display pins.

## Interface
- DIGITS, 4: number of hex digit positions, ≥1; position DIGITS is the sign digit.
- REFRESH_DIV, 50000: clock cycles per scan slot, ≥2.
- LZB, 1: 1 enables leading-zero blanking, 0 disables it.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  hex value; nibble k is digit position k, position 0 is least significant.
- neg  in  1  sign; 1 means show minus.
- load  in  1  one-cycle strobe; captures value/neg.
- seg  out  7  segments {a,b,c,d,e,f,g} = seg[6:0], active low.
- an  out  DIGITS+1  digit enables, active low; an[DIGITS] is the sign digit.
- pending  out  1  captured update not yet applied to the display.
- frame_start  out  1  one-cycle pulse when scan wraps to position 0.

## Operation
- Registers:
  - div_cnt counts 0..REFRESH_DIV-1.
  - idx selects the slot, 0..DIGITS.
  - pend_val/pend_neg hold the captured update; disp_val/disp_neg drive the display.
  - pending flag; registered seg/an/frame_start.
- Scan: div_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and idx advances; idx wraps from DIGITS to 0. That wrap edge is the frame boundary.
- Capture: load=1 sets pend_val<=value, pend_neg<=neg, pending<=1. Repeated loads within a frame: the last one wins.
- Apply: at the frame boundary, if pending=1 then disp<=pend and pending<=0.
- If load coincides with the boundary, value/neg go directly to disp and pending ends at 0.
- Output register update, every cycle, from the current div_cnt/idx/disp:
  - div_cnt==0 (dead time): an<=all ones, seg<=7'h7F.
  - Otherwise: an<=~(1<<idx).
    - idx<DIGITS: seg<=decode of nibble idx, or 7'h7F if that nibble is blanked.
    - idx==DIGITS: seg<=7'h7E if disp_neg, else 7'h7F.
- Decode, 0..F → 01,4F,12,06,4C,24,20,0F,00,04,08,60,31,42,30,38 (hex, 7-bit).
- Blanking (LZB=1): position k≥1 is blanked iff nibble k and all higher nibbles are zero. Position 0 is never blanked. With LZB=0 nothing is blanked.
- frame_start: registered. It is 1 for exactly the cycle after the frame boundary.

## Timing
- Reset (async, immediate): seg=7'h7F, an=all ones, pending=0, frame_start=0, div_cnt=0, idx=0, disp/pend=0.
- After rst_n deasserts:
  - First edge: dead-time outputs.
  - Second edge: an[0]=0 showing disp nibble 0.
- Each slot:
  - 1 dead-time cycle, then REFRESH_DIV-1 cycles with one an bit low.
  - Frame period = (DIGITS+1)*REFRESH_DIV cycles.
- Latency load → seg:
  - Update applied at the next frame boundary.
  - The first visible digit is position 0, shown 2 cycles after the boundary edge, because the dead-time slot comes first.
- At most one an bit is low at any time. an never changes directly from one low bit to another; a dead-time cycle always intervenes.
- Reset asserted mid-scan or mid-pending: all state clears immediately and the pending update is lost.

## Test plan
DIGITS=4, REFRESH_DIV=4, LZB=1 unless noted.
- Reset:
  - Assert rst_n=0 mid-slot → seg=7F and an=5'b11111 in the same cycle, pending=0.
  - Release → first an=5'b11110 appears at the second edge with seg=01.
- Update and scan:
  - load value=16'h0A3F, neg=0 → pending=1 until the boundary, then frame_start pulses.
  - Scan shows (an, seg) = (11110, 38), (11101, 06), (11011, 08), (10111, 7F), (01111, 7F).
  - A dead-time cycle with an=11111, seg=7F precedes each slot.
- Sign and blanking:
  - load value=16'h0005, neg=1 → positions 1–3 show 7F, position 0 shows 24, sign shows 7E.
  - Repeat with LZB=0 → positions 1–3 show 01.
- Zero value:
  - load value=16'h0000, neg=0 → position 0 shows 01, every other position shows 7F.
- Load ordering:
  - Loads of 16'h1111 then 16'h2222 in the same frame → only 2222 is displayed (seg=12 on all digits).
  - load coinciding with the boundary cycle → applied that boundary and pending stays 0.
- Period check:
  - Count cycles between frame_start pulses → exactly 20.
  - At most one an bit is ever low, checked across 3 frames.

Source files
------------

// File: rtl/hex_scan_display.sv
// -----------------------------------------------------------------------------
// hex_scan_display
//
// Time-multiplexed driver for a bank of common-anode seven-segment digits plus
// one sign digit. A packed hex value and a sign are captured on a load strobe
// and copied to the display registers only at the frame boundary, so a frame
// in flight never shows a mix of old and new digits. The scan visits one
// position per slot. Each slot opens with a single dead-time cycle that turns
// every digit off. This stops ghosting when the anode moves to the next digit.
//
// Parameters
//   DIGITS       number of hex digit positions (>=1); position DIGITS is sign
//   REFRESH_DIV  clock cycles per scan slot (>=2)
//   LZB          1 enables leading-zero blanking, 0 shows every nibble
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   value        hex value, nibble k drives position k (0 = least significant)
//   neg          sign, 1 shows a minus on the sign digit
//   load         one-cycle strobe capturing value/neg
//   seg          segments {a,b,c,d,e,f,g} = seg[6:0], active low
//   an           digit enables, active low; an[DIGITS] is the sign digit
//   pending      a captured update is waiting for the next frame boundary
//   frame_start  one-cycle pulse in the cycle after the scan wraps to 0
// -----------------------------------------------------------------------------
module hex_scan_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LZB         = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  neg,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [DIGITS:0]       an,
    output logic                  pending,
    output logic                  frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(DIGITS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS);

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h7E;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] pend_val;
    logic                pend_neg;
    logic [4*DIGITS-1:0] disp_val;
    logic                disp_neg;

    // Last cycle of the last slot: the next edge wraps the scan to position 0.
    logic frame_boundary;
    assign frame_boundary = (div_cnt == CNT_MAX) && (idx == IDX_MAX);

    // -------------------------------------------------------------------------
    // Segment decode for one hex nibble (active low, {a..g}).
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Scan timing: div_cnt paces the slot, idx picks the position.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the values from before the edge; combinational blocks use
    // blocking assignments because they evaluate in order like software.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == CNT_MAX) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Capture and frame-synchronous apply.
    // A load on the boundary cycle bypasses the pending stage so it takes
    // effect at this boundary rather than one frame later.
    // -------------------------------------------------------------------------
    // NOTE: the value registers are reset even though they are plain data;
    // the display must come out of reset showing a known zero, and the pending
    // copy must not leak a stale update into the first frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_neg <= 1'b0;
            disp_val <= '0;
            disp_neg <= 1'b0;
            pending  <= 1'b0;
        end else if (frame_boundary) begin
            if (load) begin
                disp_val <= value;
                disp_neg <= neg;
                pend_val <= value;
                pend_neg <= neg;
            end else if (pending) begin
                disp_val <= pend_val;
                disp_neg <= pend_neg;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pend_neg <= neg;
            pending  <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero blanking: position k (k>=1) is dark when it and every
    // higher nibble are zero. Position 0 always shows, so zero reads "0".
    // -------------------------------------------------------------------------
    logic [DIGITS-1:0] blank;
    logic              higher_zero;

    // NOTE: every signal driven here gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        blank       = '0;
        higher_zero = 1'b1;
        if (LZB != 0) begin
            for (int k = DIGITS - 1; k >= 1; k--) begin
                higher_zero = higher_zero && (disp_val[4*k +: 4] == 4'h0);
                blank[k]    = higher_zero;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Select the nibble and enable pattern for the current position. A mux
    // loop is used because idx can equal DIGITS (the sign slot), which would
    // fall outside disp_val with an indexed part-select.
    // -------------------------------------------------------------------------
    logic [3:0]    cur_nib;
    logic          cur_blank;
    logic [DIGITS:0] an_sel;

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = disp_val[4*k +: 4];
                cur_blank = blank[k];
            end
        end
    end

    always_comb begin
        an_sel = '1;
        for (int k = 0; k <= DIGITS; k++) begin
            an_sel[k] = (idx != IDX_W'(k));
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs. The first cycle of every slot is dead time, so two
    // different anodes are never enabled on consecutive cycles.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_OFF;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_boundary;
            if (div_cnt == '0) begin
                seg <= SEG_OFF;
                an  <= '1;
            end else begin
                an <= an_sel;
                if (idx == IDX_MAX) begin
                    seg <= disp_neg ? SEG_MINUS : SEG_OFF;
                end else begin
                    seg <= cur_blank ? SEG_OFF : hex_to_seg(cur_nib);
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_display
//
// Drives two copies of hex_scan_display (DIGITS=4, REFRESH_DIV=4), one with
// leading-zero blanking and one without, from the same stimulus. The driver
// predicts every registered output from cycle arithmetic (slot = cycle/4,
// phase = cycle%4) and a simple model of which value is on display, and pushes
// the prediction into a queue. A monitor on the falling edge pops and compares,
// and also watches the one-anode-low, dead-time and frame-period invariants.
// -----------------------------------------------------------------------------
module tb_hex_scan_display;

    localparam int D     = 4;
    localparam int R     = 4;
    localparam int FRAME = (D + 1) * R;

    logic          clk;
    logic          rst_n;
    logic [15:0]   value;
    logic          neg;
    logic          load;

    logic [6:0]    seg_a, seg_b;
    logic [D:0]    an_a, an_b;
    logic          pending_a, pending_b;
    logic          fs_a, fs_b;

    hex_scan_display #(.DIGITS(D), .REFRESH_DIV(R), .LZB(1)) dut_lzb (
        .clk(clk), .rst_n(rst_n), .value(value), .neg(neg), .load(load),
        .seg(seg_a), .an(an_a), .pending(pending_a), .frame_start(fs_a)
    );

    hex_scan_display #(.DIGITS(D), .REFRESH_DIV(R), .LZB(0)) dut_nolzb (
        .clk(clk), .rst_n(rst_n), .value(value), .neg(neg), .load(load),
        .seg(seg_b), .an(an_b), .pending(pending_b), .frame_start(fs_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -------------------------------------------------------------------------
    // Checking bookkeeping
    // -------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [6:0] dec_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // What a lit slot shows for position ix of value v / sign n.
    function automatic logic [6:0] slot_seg(input int ix, input logic [15:0] v,
                                            input logic n, input bit lzb);
        logic [15:0] upper;
        if (ix == D) return n ? 7'h7E : 7'h7F;
        upper = v >> (4 * ix);
        if (lzb && ix >= 1 && upper == 16'h0) return 7'h7F;
        return dec_tab[int'(upper & 16'hF)];
    endfunction

    typedef struct {
        logic [D:0] an;
        logic [6:0] seg_lzb;
        logic [6:0] seg_nolzb;
        logic       fs;
        logic       pend;
    } exp_t;

    exp_t sb[$];

    int          edges;      // clock edges since reset release
    logic [15:0] m_disp;
    logic        m_neg;
    logic [15:0] m_pval;
    logic        m_pneg;
    logic        m_pending;

    task automatic model_clear();
        edges     = 0;
        m_disp    = '0;
        m_neg     = 1'b0;
        m_pval    = '0;
        m_pneg    = 1'b0;
        m_pending = 1'b0;
    endtask

    // One clock: present inputs, predict the outputs after the coming edge,
    // advance the model, and hand the prediction to the monitor.
    task automatic step(input logic ld, input logic [15:0] v, input logic n);
        exp_t x;
        int   phase, slot;
        bit   bnd;
        load  = ld;
        value = v;
        neg   = n;
        phase = edges % R;
        slot  = (edges / R) % (D + 1);
        bnd   = (edges % FRAME) == FRAME - 1;
        if (phase == 0) begin
            x.an        = '1;
            x.seg_lzb   = 7'h7F;
            x.seg_nolzb = 7'h7F;
        end else begin
            x.an        = ~((D+1)'(1) << slot);
            x.seg_lzb   = slot_seg(slot, m_disp, m_neg, 1'b1);
            x.seg_nolzb = slot_seg(slot, m_disp, m_neg, 1'b0);
        end
        x.fs = bnd;
        if (bnd) begin
            if (ld) begin
                m_disp = v;
                m_neg  = n;
            end else if (m_pending) begin
                m_disp = m_pval;
                m_neg  = m_pneg;
            end
            m_pending = 1'b0;
        end else if (ld) begin
            m_pval    = v;
            m_pneg    = n;
            m_pending = 1'b1;
        end
        x.pend = m_pending;
        @(posedge clk);
        sb.push_back(x);
        edges++;
        #1;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
    endtask

    // Idle until the next edge to be taken has the given frame offset.
    task automatic run_until(input int off);
        for (int i = 0; i < FRAME && (edges % FRAME) != off; i++) step(1'b0, 16'h0, 1'b0);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_seg_lzb"},   32'(seg_a),     32'h7F);
        check({tag, "_seg_nolzb"}, 32'(seg_b),     32'h7F);
        check({tag, "_an"},        32'(an_a),      32'h1F);
        check({tag, "_an_nolzb"},  32'(an_b),      32'h1F);
        check({tag, "_pending"},   32'(pending_a), 32'h0);
        check({tag, "_fs"},        32'(fs_a),      32'h0);
    endtask

    // Assert reset away from the clock edge and check it took effect at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        reset_check(tag);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    int         mon_cyc;
    int         last_fs;
    logic [D:0] prev_an;

    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            mon_cyc = 0;
            last_fs = -1;
            prev_an = '1;
        end else begin
            mon_cyc++;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("an",          32'(an_a),      32'(x.an));
                check("an_nolzb",    32'(an_b),      32'(x.an));
                check("seg_lzb",     32'(seg_a),     32'(x.seg_lzb));
                check("seg_nolzb",   32'(seg_b),     32'(x.seg_nolzb));
                check("frame_start", 32'(fs_a),      32'(x.fs));
                check("pending",     32'(pending_a), 32'(x.pend));
                check("pending_b",   32'(pending_b), 32'(x.pend));
            end
            check("one_an_low", 32'($countones(~an_a) <= 1), 32'h1);
            if (prev_an != '1 && an_a != '1)
                check("dead_time_between", 32'(an_a), 32'(prev_an));
            prev_an = an_a;
            if (fs_a) begin
                if (last_fs >= 0) check("frame_period", 32'(mon_cyc - last_fs), 32'(FRAME));
                last_fs = mon_cyc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst_n = 1'b1;
        value = '0;
        neg   = 1'b0;
        load  = 1'b0;
        model_clear();
        #2;
        rst_n = 1'b0;
        #1;
        reset_check("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Run into a slot, then reset mid-slot.
        run(7);
        do_reset("mid_slot");

        // Zero display after reset.
        run(2 * FRAME);

        // Mixed digits with a blanked top nibble.
        run_until(5);
        step(1'b1, 16'h0A3F, 1'b0);
        run(2 * FRAME);

        // Small negative value.
        run_until(7);
        step(1'b1, 16'h0005, 1'b1);
        run(2 * FRAME);

        // Explicit zero.
        run_until(2);
        step(1'b1, 16'h0000, 1'b0);
        run(2 * FRAME);

        // Two loads in one frame: last one wins.
        run_until(1);
        step(1'b1, 16'h1111, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        run(2 * FRAME);

        // Load on the boundary cycle goes straight to the display.
        run_until(FRAME - 1);
        step(1'b1, 16'hBEEF, 1'b1);
        run(FRAME + 5);

        // Reset while an update is pending: the update is lost.
        run_until(3);
        step(1'b1, 16'h1234, 1'b1);
        run(2);
        do_reset("mid_pending");
        run(2 * FRAME);

        // Random loads.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                step(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
            else
                step(1'b0, 16'h0, 1'b0);
        end
        run(FRAME);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
